// File: rtl/serial_pattern_source_if.sv
// rtl/serial_pattern_source_if.sv - load-side valid/ready handshake for serial_pattern_source
interface serial_pattern_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Load_Data;
  logic             Load_Valid;
  logic             Load_Ready;

  modport master (output Load_Data, output Load_Valid, input Load_Ready);
  modport slave  (input Load_Data, input Load_Valid, output Load_Ready);
endinterface

// File: rtl/serial_pattern_source.sv
// rtl/serial_pattern_source.sv - MSB-first parallel-to-serial source with idle level and gap; SER_PARITY_EN appends an even-parity bit
module serial_pattern_source #(
  parameter int WIDTH      = 8,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter int GAP_CYCLES = 0,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic                   CLK,
  input  logic                   Reset,
  serial_pattern_source_if.slave load,
  output logic                   Serial_Out,
  output logic                   Serial_Valid,
  output logic                   Busy,
  output logic [CW-1:0]          Bit_Count
);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [7:0]       gap_q;
  logic             out_q;
  logic             valid_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
`ifdef SER_PARITY_EN
  logic             parity_q;
`endif

  logic last_bit;
  logic word_end;
  logic ready;
  logic accept;

  assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
`ifdef SER_PARITY_EN
  assign word_end = (state_q == S_PARITY);
`else
  assign word_end = last_bit;
`endif
  // The back-to-back window is the final serial cycle, only when no gap follows.
  assign ready  = (state_q == S_IDLE) || (word_end && (GAP_CYCLES == 0));
  assign accept = load.Load_Valid && ready;

  assign load.Load_Ready = ready;
  assign Serial_Out      = out_q;
  assign Serial_Valid    = valid_q;
  assign Busy            = busy_q;
  assign Bit_Count       = cnt_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      gap_q    <= '0;
      out_q    <= IDLE_LEVEL;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (accept) begin
      state_q  <= S_SHIFT;
      shift_q  <= load.Load_Data;
      out_q    <= load.Load_Data[WIDTH-1];
      valid_q  <= 1'b1;
      busy_q   <= 1'b1;
      cnt_q    <= '0;
`ifdef SER_PARITY_EN
      parity_q <= ^load.Load_Data;
`endif
    end else if (word_end) begin
      out_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      if (GAP_CYCLES > 0) begin
        state_q <= S_GAP;
        gap_q   <= GAP_LAST;
        busy_q  <= 1'b1;
      end else begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end
`ifdef SER_PARITY_EN
    end else if (last_bit) begin
      state_q <= S_PARITY;
      out_q   <= parity_q;
      cnt_q   <= CW'(WIDTH);
`endif
    end else begin
      case (state_q)
        S_SHIFT: begin
          // shift_q still holds the bit on Serial_Out in its MSB.
          shift_q <= shift_q << 1;
          out_q   <= shift_q[WIDTH-2];
          cnt_q   <= cnt_q + CW'(1);
        end
        S_GAP: begin
          if (gap_q == 8'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_source.sv
// tb/tb_serial_pattern_source.sv - bench for serial_pattern_source (gap 0 and gap 2 instances) against a word-expansion model
module tb_serial_pattern_source;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  localparam bit IDLE = 1'b1;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = W + (PAR ? 1 : 0);

  typedef struct packed {
    logic          out;
    logic          valid;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          last;
  } tup_t;

  logic clk = 1'b0;
  logic rst;
  logic lv;
  logic [W-1:0] ld;

  logic [1:0]         so, s_valid, by, rdy;
  logic [1:0][CW-1:0] bc;

  serial_pattern_source_if #(.WIDTH(W)) if0 ();
  serial_pattern_source_if #(.WIDTH(W)) if1 ();
  assign if0.Load_Valid = lv;
  assign if0.Load_Data  = ld;
  assign if1.Load_Valid = lv;
  assign if1.Load_Data  = ld;
  assign rdy = {if1.Load_Ready, if0.Load_Ready};

  serial_pattern_source #(.WIDTH(W), .IDLE_LEVEL(IDLE), .GAP_CYCLES(0)) dut_g0 (
    .CLK(clk), .Reset(rst), .load(if0.slave),
    .Serial_Out(so[0]), .Serial_Valid(s_valid[0]), .Busy(by[0]), .Bit_Count(bc[0])
  );
  serial_pattern_source #(.WIDTH(W), .IDLE_LEVEL(IDLE), .GAP_CYCLES(2)) dut_g2 (
    .CLK(clk), .Reset(rst), .load(if1.slave),
    .Serial_Out(so[1]), .Serial_Valid(s_valid[1]), .Busy(by[1]), .Bit_Count(bc[1])
  );

  always #5 clk = ~clk;

  int   gap_of [2];
  tup_t cur [2];
  tup_t fut [2][32];
  int   fn [2];
  bit   acc [2];
  int   n_cmp, n_bad;
  bit   chk_en;

  function automatic tup_t idle_t();
    tup_t t;
    t.out = IDLE; t.valid = 1'b0; t.cnt = '0; t.busy = 1'b0; t.last = 1'b0;
    return t;
  endfunction

  function automatic bit ready_exp(input int k);
    return (fn[k] == 0) && (!cur[k].busy || (cur[k].last && gap_of[k] == 0));
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s (gap=%0d) observed=%0h expected=%0h", tag, gap_of[k], obs, exp_v);
    end
  endtask

  // A word expands into its full list of future output cycles: data, parity, gap.
  task automatic push_word(input int k, input logic [W-1:0] w);
    tup_t t;
    fn[k] = 0;
    for (int i = 0; i < W; i++) begin
      t.out = w[W-1-i]; t.valid = 1'b1; t.cnt = CW'(i); t.busy = 1'b1;
      t.last = (i == W - 1) && !PAR;
      fut[k][fn[k]] = t; fn[k] = fn[k] + 1;
    end
    if (PAR) begin
      t.out = ^w; t.valid = 1'b1; t.cnt = CW'(W); t.busy = 1'b1; t.last = 1'b1;
      fut[k][fn[k]] = t; fn[k] = fn[k] + 1;
    end
    for (int i = 0; i < gap_of[k]; i++) begin
      t.out = IDLE; t.valid = 1'b0; t.cnt = '0; t.busy = 1'b1; t.last = 1'b0;
      fut[k][fn[k]] = t; fn[k] = fn[k] + 1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (rst) begin
        fn[k] = 0;
        cur[k] = idle_t();
      end else begin
        if (lv && ready_exp(k)) begin
          acc[k] = 1'b1;
          push_word(k, ld);
        end
        if (fn[k] > 0) begin
          cur[k] = fut[k][0];
          for (int i = 0; i < fn[k] - 1; i++) fut[k][i] = fut[k][i+1];
          fn[k] = fn[k] - 1;
        end else begin
          cur[k] = idle_t();
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
    rst = r; lv = v; ld = d;
    #1;
    if (chk_en)
      for (int k = 0; k < 2; k++) chk("ready", k, rdy[k], ready_exp(k));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk_en)
      for (int k = 0; k < 2; k++) begin
        chk("serial_out", k, so[k], cur[k].out);
        chk("serial_valid", k, s_valid[k], cur[k].valid);
        chk("busy", k, by[k], cur[k].busy);
        chk("bit_count", k, bc[k], cur[k].cnt);
      end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  wrd;
    logic [31:0]   strm;
    int            nbits, streak, guard, vcnt, gap_ones;

    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    gap_of[0] = 0; gap_of[1] = 2;
    for (int k = 0; k < 2; k++) begin cur[k] = idle_t(); fn[k] = 0; acc[k] = 1'b0; end
    rst = 1'b1; lv = 1'b0; ld = '0;

    // Reset held two cycles
    cycle(1'b1, 1'b0, '0);
    chk_en = 1'b1;
    cycle(1'b1, 1'b0, '0);
    chk("rst_out", 0, so[0], 1);
    chk("rst_valid", 0, s_valid[0], 0);
    chk("rst_busy", 1, by[1], 0);
    chk("rst_cnt", 1, bc[1], 0);
    chk("rst_ready", 1, rdy[1], 1);

    // 0xA5 through the gap=2 instance
    cycle(1'b0, 1'b1, 8'hA5);
    wrd = '0; vcnt = 0; gap_ones = 0;
    for (int c = 1; c <= NB + 2; c++) begin
      if (c <= W) begin
        wrd = {wrd[W-2:0], so[1]};
        vcnt += int'(s_valid[1]);
        chk("a5_bitcnt", 1, bc[1], c - 1);
      end else if (c > NB) begin
        vcnt += int'(s_valid[1]);
        gap_ones += int'(so[1]);
        chk("gap_ready", 1, rdy[1], 0);
      end
      cycle(1'b0, 1'b0, '0);
    end
    chk("a5_word", 1, wrd, 8'hA5);
    chk("a5_valid_cycles", 1, vcnt, W);
    chk("gap_idle_level", 1, gap_ones, 2);
    chk("post_gap_ready", 1, rdy[1], 1);

    // Back-to-back 0x12 then 0x34 on the gap=0 instance
    cycle(1'b1, 1'b0, '0);
    strm = '0; nbits = 0; streak = 0;
    cycle(1'b0, 1'b1, 8'h12);
    if (s_valid[0]) begin streak++; if (bc[0] < CW'(W)) begin strm = {strm[30:0], so[0]}; nbits++; end end
    guard = 0;
    do begin
      cycle(1'b0, 1'b1, 8'h34);
      if (s_valid[0]) begin streak++; if (bc[0] < CW'(W)) begin strm = {strm[30:0], so[0]}; nbits++; end end
      guard++;
    end while (!acc[0] && guard < 20);
    guard = 0;
    while (s_valid[0] && guard < 40) begin
      cycle(1'b0, 1'b0, '0);
      if (s_valid[0]) begin streak++; if (bc[0] < CW'(W)) begin strm = {strm[30:0], so[0]}; nbits++; end end
      guard++;
    end
    chk("b2b_stream", 0, strm[15:0], 16'h1234);
    chk("b2b_bits", 0, nbits, 16);
    chk("b2b_contiguous", 0, streak, 2 * NB);

    // Reset in the middle of 0xFF
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'hFF);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, '0);
    chk("ff_cnt3", 0, bc[0], 3);
    cycle(1'b1, 1'b1, 8'hFF);
    chk("midrst_out", 0, so[0], 1);
    chk("midrst_valid", 0, s_valid[0], 0);
    chk("midrst_busy", 0, by[0], 0);
    chk("midrst_ready", 0, rdy[0], 1);
    cycle(1'b1, 1'b1, 8'hAA);
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 1'b0, '0);
      vcnt += int'(s_valid[0]) + int'(s_valid[1]);
    end
    chk("rst_drops_word", 0, vcnt, 0);

    // Load_Valid during SHIFT is ignored
    cycle(1'b0, 1'b1, 8'h0F);
    vcnt = int'(s_valid[0]);
    for (int c = 0; c < 2; c++) begin cycle(1'b0, 1'b0, '0); vcnt += int'(s_valid[0]); end
    cycle(1'b0, 1'b1, 8'hF0);
    vcnt += int'(s_valid[0]);
    for (int c = 0; c < 14; c++) begin cycle(1'b0, 1'b0, '0); vcnt += int'(s_valid[0]); end
    chk("no_queue", 0, vcnt, NB);

`ifdef SER_PARITY_EN
    cycle(1'b0, 1'b1, 8'h07);
    for (int c = 1; c < NB; c++) cycle(1'b0, 1'b0, '0);
    chk("par07_bit", 0, so[0], 1);
    chk("par07_cnt", 0, bc[0], W);
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h03);
    for (int c = 1; c < NB; c++) cycle(1'b0, 1'b0, '0);
    chk("par03_bit", 0, so[0], 0);
    chk("par03_valid", 0, s_valid[0], 1);
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, '0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++)
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), W'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
